// File: rtl/ex_csa_accum_pkg.sv
// rtl/ex_csa_accum_pkg.sv - shared types for the carry-save accumulator
//
// Purpose: FSM state encoding shared by the accumulator top and its bench.
// Ports:   none (package).
package ex_csa_accum_pkg;

  // ACC absorbs beats; RES_LO/RES_HI resolve the redundant pair in two
  // halves; DONE holds the result until the consumer takes it.
  typedef enum logic [1:0] {
    ACC    = 2'd0,
    RES_LO = 2'd1,
    RES_HI = 2'd2,
    DONE   = 2'd3
  } accState_e;

endpackage

// File: rtl/ex_csa3x2_n.sv
// rtl/ex_csa3x2_n.sv - bitwise WIDTH-bit 3:2 compressor
//
// Purpose: reduces three vectors to a sum vector and an unshifted carry
//          vector with x + y + z == sum + 2*carry. The caller shifts the
//          carry vector and chooses what enters its LSB.
// Ports:   x, y, z  in  WIDTH  addends
//          sum      out WIDTH  bitwise xor of the addends
//          carry    out WIDTH  bitwise majority (weight 2, not shifted)
module ex_csa3x2_n #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/ex_csa_accum.sv
// rtl/ex_csa_accum.sv - sequential carry-save accumulator with split resolve
//
// Purpose: accumulates two operands per beat (each optionally negated) into a
//          redundant sum/carry pair, resolves it with a two-cycle split add
//          on the last beat of a group and offers the result on a
//          valid/ready handshake.
// Ports:   clock, reset          rising-edge clock, synchronous active-high reset
//          inValid/inReady       beat handshake
//          inA, inB              operands
//          inSubA, inSubB        negate the corresponding operand
//          inLast                beat closes the group
//          outValid/outReady     result handshake
//          outSum                group sum modulo 2^WIDTH
//          outCount              beats in the group, saturating
module ex_csa_accum
  import ex_csa_accum_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNTW  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inSubA,
  input  logic             inSubB,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outSum,
  output logic [CNTW-1:0]  outCount
);

  localparam int LOW  = WIDTH / 2;
  localparam int HIGH = WIDTH - LOW;

  accState_e        state;
  accState_e        nextState;
  logic [WIDTH-1:0] sumReg;
  logic [WIDTH-1:0] carryReg;
  logic [CNTW-1:0]  count;
  logic [WIDTH-1:0] result;
  logic             cpaCarry;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] c1;
  logic [WIDTH-1:0] c1x;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] c2;
  logic [WIDTH-1:0] c2x;
  logic [LOW:0]     loSum;
  logic [HIGH-1:0]  hiSum;
  logic             accept;
  logic             take;

  // One's complement here; the matching +1 rides in the free LSB of the
  // shifted carry vector of the same stage, so negation costs no adder.
  assign opA = inSubA ? ~inA : inA;
  assign opB = inSubB ? ~inB : inB;

  ex_csa3x2_n #(.WIDTH(WIDTH)) stage1 (
    .x    (sumReg),
    .y    (carryReg),
    .z    (opA),
    .sum  (s1),
    .carry(c1)
  );

  // Shift drops the carry out of the MSB, giving modulo-2^WIDTH arithmetic.
  assign c1x = (c1 << 1) | {{(WIDTH-1){1'b0}}, inSubA};

  ex_csa3x2_n #(.WIDTH(WIDTH)) stage2 (
    .x    (s1),
    .y    (c1x),
    .z    (opB),
    .sum  (s2),
    .carry(c2)
  );

  assign c2x = (c2 << 1) | {{(WIDTH-1){1'b0}}, inSubB};

  // Split carry-propagate add: low half in RES_LO, high half plus the
  // registered low carry in RES_HI.
  assign loSum = {1'b0, sumReg[LOW-1:0]} + {1'b0, carryReg[LOW-1:0]};
  assign hiSum = sumReg[WIDTH-1:LOW] + carryReg[WIDTH-1:LOW]
               + {{(HIGH-1){1'b0}}, cpaCarry};

  assign accept = inValid && inReady;
  assign take   = outValid && outReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ACC;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      ACC: begin
        inReady = 1'b1;
        if (inValid && inLast) begin
          nextState = RES_LO;
        end
      end
      RES_LO: nextState = RES_HI;
      RES_HI: nextState = DONE;
      DONE: begin
        outValid = 1'b1;
        if (outReady) begin
          nextState = ACC;
        end
      end
      default: nextState = ACC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sumReg   <= '0;
      carryReg <= '0;
      count    <= '0;
      result   <= '0;
      cpaCarry <= 1'b0;
    end else begin
      if (accept) begin
        sumReg   <= s2;
        carryReg <= c2x;
        if (count != {CNTW{1'b1}}) begin
          count <= count + CNTW'(1);
        end
      end
      if (state == RES_LO) begin
        result[LOW-1:0] <= loSum[LOW-1:0];
        cpaCarry        <= loSum[LOW];
      end
      if (state == RES_HI) begin
        result[WIDTH-1:LOW] <= hiSum;
      end
      // Result register is left alone so outSum stays readable after the take.
      if (take) begin
        sumReg   <= '0;
        carryReg <= '0;
        count    <= '0;
      end
    end
  end

  assign outSum   = result;
  assign outCount = count;

endmodule

// File: tb/tb_ex_csa_accum.sv
// tb/tb_ex_csa_accum.sv - self-checking bench for ex_csa_accum
module tb_ex_csa_accum;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [63:0] inA;
  logic [63:0] inB;
  logic        inSubA;
  logic        inSubB;
  logic        inLast;
  logic        outValid;
  logic        outReady;
  logic [63:0] outSum;
  logic [7:0]  outCount;

  logic        inValid2;
  logic        inReady2;
  logic [63:0] inA2;
  logic [63:0] inB2;
  logic        inLast2;
  logic        outValid2;
  logic        outReady2;
  logic [63:0] outSum2;
  logic [1:0]  outCount2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ex_csa_accum #(.WIDTH(64), .CNTW(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .inValid (inValid),
    .inReady (inReady),
    .inA     (inA),
    .inB     (inB),
    .inSubA  (inSubA),
    .inSubB  (inSubB),
    .inLast  (inLast),
    .outValid(outValid),
    .outReady(outReady),
    .outSum  (outSum),
    .outCount(outCount)
  );

  ex_csa_accum #(.WIDTH(64), .CNTW(2)) dutSat (
    .clock   (clock),
    .reset   (reset),
    .inValid (inValid2),
    .inReady (inReady2),
    .inA     (inA2),
    .inB     (inB2),
    .inSubA  (1'b0),
    .inSubB  (1'b0),
    .inLast  (inLast2),
    .outValid(outValid2),
    .outReady(outReady2),
    .outSum  (outSum2),
    .outCount(outCount2)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        subA;
    logic        subB;
    logic        last;
    logic [63:0] expSum;
    logic [7:0]  expCount;
  } vec_t;

  vec_t vecs[8];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic sendBeat(input logic [63:0] a, input logic [63:0] b,
                          input logic sa, input logic sb, input logic last);
    @(negedge clock);
    checkVal("inReady before beat", 64'(inReady), 64'd1);
    inA     = a;
    inB     = b;
    inSubA  = sa;
    inSubB  = sb;
    inLast  = last;
    inValid = 1'b1;
    @(posedge clock);
  endtask

  task automatic waitResult(input string name, input logic [63:0] expSum, input logic [7:0] expCount);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clock);
      inValid = 1'b0;
      if (outValid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkVal({name, " latency"}, 64'(lat), 64'd3);
    checkVal({name, " sum"}, outSum, expSum);
    checkVal({name, " count"}, 64'(outCount), 64'(expCount));
  endtask

  task automatic takeResult(input string name);
    outReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    outReady = 1'b0;
    checkVal({name, " outValid after take"}, 64'(outValid), 64'd0);
    checkVal({name, " inReady after take"}, 64'(inReady), 64'd1);
  endtask

  initial begin
    vecs[0] = '{64'd5, 64'd7, 1'b0, 1'b0, 1'b1, 64'd12, 8'd1};
    vecs[1] = '{64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0};
    vecs[2] = '{64'd3, 64'd4, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 64'd10, 8'd3};
    vecs[4] = '{64'd100, 64'd30, 1'b1, 1'b0, 1'b0, 64'd0, 8'd0};
    vecs[5] = '{64'd0, 64'd0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFBA, 8'd2};
    vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 8'd1};
    vecs[7] = '{64'd0, 64'd5, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 8'd1};

    reset     = 1'b1;
    inValid   = 1'b0;
    inA       = '0;
    inB       = '0;
    inSubA    = 1'b0;
    inSubB    = 1'b0;
    inLast    = 1'b0;
    outReady  = 1'b0;
    inValid2  = 1'b0;
    inA2      = '0;
    inB2      = '0;
    inLast2   = 1'b0;
    outReady2 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkVal("reset inReady", 64'(inReady), 64'd1);
    checkVal("reset outValid", 64'(outValid), 64'd0);
    checkVal("reset outSum", outSum, 64'd0);
    checkVal("reset outCount", 64'(outCount), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sendBeat(vecs[i].a, vecs[i].b, vecs[i].subA, vecs[i].subB, vecs[i].last);
      if (vecs[i].last) begin
        waitResult($sformatf("vec%0d", i), vecs[i].expSum, vecs[i].expCount);
        takeResult($sformatf("vec%0d", i));
      end
    end

    // Backpressure: result must hold while junk beats are offered.
    sendBeat(64'd9, 64'd1, 1'b0, 1'b0, 1'b1);
    waitResult("bp", 64'd10, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      inA     = 64'(i) + 64'd77;
      inB     = 64'd1000;
      inLast  = 1'b1;
      inValid = 1'b1;
      checkVal("bp outValid held", 64'(outValid), 64'd1);
      checkVal("bp outSum held", outSum, 64'd10);
      checkVal("bp inReady low", 64'(inReady), 64'd0);
    end
    inValid = 1'b0;
    takeResult("bp");
    sendBeat(64'd2, 64'd2, 1'b0, 1'b0, 1'b1);
    waitResult("bp next", 64'd4, 8'd1);
    takeResult("bp next");

    // Reset while resolving: the group is dropped without output.
    sendBeat(64'd50, 64'd50, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    inValid = 1'b0;
    checkVal("rst RES_LO outValid", 64'(outValid), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkVal("rst outValid", 64'(outValid), 64'd0);
    checkVal("rst inReady", 64'(inReady), 64'd1);
    checkVal("rst outSum", outSum, 64'd0);
    checkVal("rst outCount", 64'(outCount), 64'd0);
    sendBeat(64'd2, 64'd3, 1'b0, 1'b0, 1'b1);
    waitResult("after rst", 64'd5, 8'd1);
    takeResult("after rst");

    // Count saturation on the CNTW=2 instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkVal("sat inReady", 64'(inReady2), 64'd1);
      inA2     = 64'd1;
      inB2     = 64'd0;
      inLast2  = (i == 4);
      inValid2 = 1'b1;
      @(posedge clock);
    end
    begin
      bit seen2;
      seen2 = 1'b0;
      for (int i = 0; i < 8 && !seen2; i++) begin
        @(negedge clock);
        inValid2 = 1'b0;
        if (outValid2) seen2 = 1'b1;
      end
      checkVal("sat outValid", 64'(seen2), 64'd1);
    end
    checkVal("sat sum", outSum2, 64'd5);
    checkVal("sat count", 64'(outCount2), 64'd3);
    outReady2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    outReady2 = 1'b0;
    checkVal("sat outValid after take", 64'(outValid2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
